// File: rtl/otg_hpi_pkg.sv
// Shared HPI bus-sequencer types: FSM state codes, HPI register selects, phase counter width.
// Combinational helpers only; no latency, no backpressure.
package otg_hpi_pkg;

  localparam int PHASE_CNT_W = 4;

  typedef logic [2:0] hpi_state_t;

  localparam hpi_state_t ST_IDLE    = 3'd0;
  localparam hpi_state_t ST_SETUP   = 3'd1;
  localparam hpi_state_t ST_STROBE  = 3'd2;
  localparam hpi_state_t ST_HOLD    = 3'd3;
  localparam hpi_state_t ST_RECOVER = 3'd4;

  localparam logic [1:0] HPI_DATA    = 2'd0;
  localparam logic [1:0] HPI_MAILBOX = 2'd1;
  localparam logic [1:0] HPI_ADDR    = 2'd2;
  localparam logic [1:0] HPI_STATUS  = 2'd3;

  // A phase of N cycles loads N-1 and exits when the counter reads zero.
  function automatic logic [PHASE_CNT_W-1:0] phase_load(input int n);
    return PHASE_CNT_W'(n - 1);
  endfunction

endpackage

// File: rtl/otg_hpi_irq_sync.sv
// HPI interrupt: 2-flop synchronizer, rising-edge detect, sticky flag cleared by clr.
// Flag rises 3 clocks after hpi_int; no backpressure (a new edge beats a same-cycle clear).
module otg_hpi_irq_sync (
  input  logic clk,
  input  logic reset,
  input  logic async_in,
  input  logic clr,
  output logic irq
);

  logic sync1, sync2, sync2_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      sync2_q <= 1'b0;
      irq     <= 1'b0;
    end else begin
      sync1   <= async_in;
      sync2   <= sync1;
      sync2_q <= sync2;
      if (sync2 && !sync2_q)
        irq <= 1'b1;
      else if (clr)
        irq <= 1'b0;
    end
  end

endmodule

// File: rtl/otg_hpi_bus_sequencer.sv
// One HPI access -> timed CY7C67200 bus cycle (SETUP/STROBE/HOLD/RECOVER); rsp_valid SETUP+STROBE+1 clocks after accept.
// cmd_ready only in IDLE, so one access in flight. OTG_HPI_IRQ_SYNC_EN adds hpi_int/hpi_irq.
module otg_hpi_bus_sequencer
  import otg_hpi_pkg::*;
#(
  parameter int SETUP_CYC   = 2,
  parameter int STROBE_CYC  = 4,
  parameter int HOLD_CYC    = 2,
  parameter int RECOVER_CYC = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [1:0]  cmd_addr,
  input  logic [15:0] cmd_wdata,
  output logic        rsp_valid,
  output logic [15:0] rsp_rdata,
  output logic        busy,
`ifdef OTG_HPI_IRQ_SYNC_EN
  input  logic        hpi_int,
  output logic        hpi_irq,
`endif
  output logic [1:0]  hpi_addr,
  output logic        hpi_cs_n,
  output logic        hpi_rd_n,
  output logic        hpi_wr_n,
  output logic [15:0] hpi_dout,
  output logic        hpi_dout_en,
  input  logic [15:0] hpi_din
);

  hpi_state_t             state;
  logic [PHASE_CNT_W-1:0] cnt;
  logic                   lat_write;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      lat_write   <= 1'b0;
      cmd_ready   <= 1'b1;
      busy        <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      hpi_addr    <= '0;
      hpi_cs_n    <= 1'b1;
      hpi_rd_n    <= 1'b1;
      hpi_wr_n    <= 1'b1;
      hpi_dout    <= '0;
      hpi_dout_en <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (cmd_valid && cmd_ready) begin
            lat_write <= cmd_write;
            hpi_addr  <= cmd_addr;
            hpi_cs_n  <= 1'b0;
            busy      <= 1'b1;
            cmd_ready <= 1'b0;
            if (cmd_write) begin
              hpi_dout    <= cmd_wdata;
              hpi_dout_en <= 1'b1;
            end
            cnt   <= phase_load(SETUP_CYC);
            state <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (cnt == '0) begin
            if (lat_write) hpi_wr_n <= 1'b0;
            else           hpi_rd_n <= 1'b0;
            cnt   <= phase_load(STROBE_CYC);
            state <= ST_STROBE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_STROBE: begin
          // Read data is captured on the edge that releases the strobe.
          if (cnt == '0) begin
            hpi_rd_n  <= 1'b1;
            hpi_wr_n  <= 1'b1;
            rsp_valid <= 1'b1;
            if (!lat_write) rsp_rdata <= hpi_din;
            cnt   <= phase_load(HOLD_CYC);
            state <= ST_HOLD;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_HOLD: begin
          if (cnt == '0) begin
            hpi_cs_n    <= 1'b1;
            hpi_dout_en <= 1'b0;
            cnt         <= phase_load(RECOVER_CYC);
            state       <= ST_RECOVER;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_RECOVER: begin
          if (cnt == '0) begin
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
            state     <= ST_IDLE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: begin
          state     <= ST_IDLE;
          cmd_ready <= 1'b1;
          busy      <= 1'b0;
          hpi_cs_n  <= 1'b1;
          hpi_rd_n  <= 1'b1;
          hpi_wr_n  <= 1'b1;
        end
      endcase
    end
  end

`ifdef OTG_HPI_IRQ_SYNC_EN
  logic irq_clr;
  assign irq_clr = rsp_valid && !lat_write && (hpi_addr == HPI_STATUS);

  otg_hpi_irq_sync u_irq_sync (
    .clk      (clk),
    .reset    (reset),
    .async_in (hpi_int),
    .clr      (irq_clr),
    .irq      (hpi_irq)
  );
`endif

endmodule

// File: tb/tb_otg_hpi_bus_sequencer.sv
// Self-checking bench for otg_hpi_bus_sequencer: directed and random accesses vs a phase-window model.
// Optional IRQ checks when OTG_HPI_IRQ_SYNC_EN is defined.
module tb_otg_hpi_bus_sequencer;

`ifdef OTG_HPI_IRQ_SYNC_EN
  localparam int S = 1, T = 1, H = 1, R = 1;
`else
  localparam int S = 2, T = 4, H = 2, R = 2;
`endif
  localparam int L = S + T + H + R;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [1:0]  cmd_addr;
  logic [15:0] cmd_wdata;
  logic        rsp_valid, busy;
  logic [15:0] rsp_rdata;
  logic [1:0]  hpi_addr;
  logic        hpi_cs_n, hpi_rd_n, hpi_wr_n, hpi_dout_en;
  logic [15:0] hpi_dout, hpi_din;
`ifdef OTG_HPI_IRQ_SYNC_EN
  logic        hpi_int, hpi_irq;
`endif

  int          n_cmp = 0;
  int          n_err = 0;
  logic [15:0] m_dout = '0;
  logic [15:0] m_rdata = '0;
  logic        m_irq = 1'b0;

  always #5 clk = ~clk;

  otg_hpi_bus_sequencer #(
    .SETUP_CYC(S), .STROBE_CYC(T), .HOLD_CYC(H), .RECOVER_CYC(R)
  ) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .busy(busy),
`ifdef OTG_HPI_IRQ_SYNC_EN
    .hpi_int(hpi_int), .hpi_irq(hpi_irq),
`endif
    .hpi_addr(hpi_addr), .hpi_cs_n(hpi_cs_n), .hpi_rd_n(hpi_rd_n), .hpi_wr_n(hpi_wr_n),
    .hpi_dout(hpi_dout), .hpi_dout_en(hpi_dout_en), .hpi_din(hpi_din)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [8:0] ctl_obs();
    return {hpi_cs_n, hpi_rd_n, hpi_wr_n, hpi_dout_en, rsp_valid, cmd_ready, busy, hpi_addr};
  endfunction

  // Expected control pins k cycles after the accept edge, from the phase windows alone.
  function automatic logic [8:0] ctl_exp(input bit w, input logic [1:0] a, input int k);
    bit act, strb;
    act  = (k <= S + T + H);
    strb = (k > S) && (k <= S + T);
    return {!act, !(strb && !w), !(strb && w), act && w, k == S + T + 1, k == L + 1, k <= L, a};
  endfunction

  task automatic chk_reset_vals(input string tag);
    chk({tag, "/ctl"}, ctl_obs(), 9'b111_0_0_1_0_00);
    chk({tag, "/dout"}, hpi_dout, 16'h0);
    chk({tag, "/rdata"}, rsp_rdata, 16'h0);
`ifdef OTG_HPI_IRQ_SYNC_EN
    chk({tag, "/irq"}, hpi_irq, 1'b0);
`endif
  endtask

  // Issue one access and check every cycle up to the return of cmd_ready.
  // chain keeps cmd_valid high with the next command during the access.
  task automatic access(input bit w, input logic [1:0] a, input logic [15:0] d, input logic [15:0] din_v,
                        input bit chain, input bit nw, input logic [1:0] na, input logic [15:0] nd,
                        input int abort_k);
    int waited = 0;
    while (!cmd_ready && waited < 50) begin
      step();
      waited++;
    end
    if (!cmd_ready) begin
      chk("ready_timeout", cmd_ready, 1'b1);
      return;
    end
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
    hpi_din = 16'($urandom);
    step();
    for (int k = 1; k <= L + 1; k++) begin
      chk($sformatf("ctl w=%0d a=%0d k=%0d", w, a, k), ctl_obs(), ctl_exp(w, a, k));
      if (w && k == 1) m_dout = d;
      chk($sformatf("dout k=%0d", k), hpi_dout, m_dout);
      if (!w && k == S + T + 1) m_rdata = din_v;
      chk($sformatf("rdata k=%0d", k), rsp_rdata, m_rdata);
`ifdef OTG_HPI_IRQ_SYNC_EN
      chk($sformatf("irq a=%0d k=%0d", a, k), hpi_irq, m_irq);
      if (!w && a == 2'd3 && k == S + T + 1) m_irq = 1'b0;
`endif
      hpi_din = (k > S && k <= S + T) ? din_v : 16'($urandom);
      if (chain) begin
        cmd_valid = 1'b1; cmd_write = nw; cmd_addr = na; cmd_wdata = nd;
      end else if (k <= L) begin
        cmd_valid = 1'($urandom); cmd_write = 1'($urandom);
        cmd_addr = 2'($urandom); cmd_wdata = 16'($urandom);
      end else begin
        cmd_valid = 1'b0;
      end
      if (k == abort_k) begin
        reset = 1'b1;
        step();
        cmd_valid = 1'b0;
        reset = 1'b0;
        m_dout = '0; m_rdata = '0; m_irq = 1'b0;
        chk_reset_vals("abort");
        for (int j = 0; j < 3; j++) begin
          step();
          chk_reset_vals("after_abort");
        end
        return;
      end
      if (k <= L) step();
    end
  endtask

  typedef struct {
    bit          w;
    logic [1:0]  a;
    logic [15:0] d;
    logic [15:0] din;
    bit          chain;
  } cmd_t;

  cmd_t rq[21];

  initial begin
    #500000;
    $display("FAIL watchdog expired compared=%0d", n_cmp);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0; hpi_din = '0;
`ifdef OTG_HPI_IRQ_SYNC_EN
    hpi_int = 1'b0;
`endif
    repeat (3) step();
    chk_reset_vals("in_reset");
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk_reset_vals("idle");
    end

    access(1'b1, 2'd2, 16'h1234, 16'h0, 1'b0, 1'b0, 2'd0, 16'h0, 0);
    access(1'b0, 2'd0, 16'h0000, 16'hBEEF, 1'b0, 1'b0, 2'd0, 16'h0, 0);
    access(1'b1, 2'd1, 16'h5555, 16'h0, 1'b0, 1'b0, 2'd0, 16'h0, 0);

    access(1'b1, 2'd3, 16'hA5A5, 16'h0, 1'b1, 1'b0, 2'd1, 16'h0000, 0);
    access(1'b0, 2'd1, 16'h0000, 16'h7E57, 1'b0, 1'b0, 2'd0, 16'h0, 0);

    access(1'b1, 2'd2, 16'hC0DE, 16'h0, 1'b0, 1'b0, 2'd0, 16'h0, 4);

    for (int i = 0; i < 21; i++) begin
      rq[i].w = 1'($urandom);
      rq[i].a = 2'($urandom);
      rq[i].d = 16'($urandom);
      rq[i].din = 16'($urandom);
      rq[i].chain = (i < 20) ? 1'($urandom) : 1'b0;
    end
    for (int i = 0; i < 20; i++)
      access(rq[i].w, rq[i].a, rq[i].d, rq[i].din, rq[i].chain,
             rq[i + 1].w, rq[i + 1].a, rq[i + 1].d, 0);

`ifdef OTG_HPI_IRQ_SYNC_EN
    hpi_int = 1'b1;
    step(); chk("irq_sync1", hpi_irq, 1'b0);
    step(); chk("irq_sync2", hpi_irq, 1'b0);
    step(); chk("irq_set", hpi_irq, 1'b1);
    m_irq = 1'b1;
    access(1'b0, 2'd0, 16'h0, 16'h1111, 1'b0, 1'b0, 2'd0, 16'h0, 0);
    access(1'b0, 2'd3, 16'h0, 16'h2222, 1'b0, 1'b0, 2'd0, 16'h0, 0);
    step();
    chk("irq_cleared", hpi_irq, 1'b0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
